// File: rtl/palabras_pkg.sv
// Shared definitions for the word/byte splitter and its receive-side counterpart.
package palabras_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } split_state_t;

  // The byte counter must be able to index every byte of a word.
  function automatic bit params_ok(input int unsigned palabras, input int unsigned bits);
    return (palabras >= 2) && (palabras <= 8) && (palabras <= (1 << (bits + 1)));
  endfunction

endpackage

// File: rtl/palabra_hold_reg.sv
// One-word hold register with full flag; a write in the same edge as a drain wins.
module palabra_hold_reg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic             drain_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  logic [WIDTH-1:0] data_q;
  logic             full_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (wr_i) begin
        data_q <= data_i;
        full_q <= 1'b1;
      end else if (drain_i) begin
        full_q <= 1'b0;
      end
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/split_palabras.sv
// Serialises a PALABRAS_ESCALE-byte word into LSB-first bytes for the UART TX.
// Optional one-word hold buffer: define SPLIT_PALABRAS_HOLD_BUF_EN.
module split_palabras
  import palabras_pkg::*;
#(
  parameter int PALABRAS_ESCALE = 2,
  parameter int BITS_ESCALE     = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PALABRAS_ESCALE*BYTE_W-1:0] data_in,
  input  logic                              flat_in,
  output logic                              ready_in,
  output logic [BYTE_W-1:0]                 tx_dato,
  output logic                              tx_start,
  input  logic                              tx_done,
  output logic                              flat_done
);

  localparam int WORD_W = PALABRAS_ESCALE * BYTE_W;
  localparam int CNT_W  = BITS_ESCALE + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PALABRAS_ESCALE - 1);

  if (!params_ok(PALABRAS_ESCALE, BITS_ESCALE)) begin : g_bad_params
    $error("split_palabras: illegal PALABRAS_ESCALE/BITS_ESCALE combination");
  end

  split_state_t      state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] shreg_q;
  logic [BYTE_W-1:0] tx_dato_q;
  logic              tx_start_q;
  logic              flat_done_q;

  logic              accept;
  logic              start_new;
  logic              last_done;
  logic [WORD_W-1:0] new_word;

  assign last_done = (state_q == WAIT) && tx_done && (cnt_q == LAST_CNT);

`ifdef SPLIT_PALABRAS_HOLD_BUF_EN
  logic              hold_full;
  logic              hold_wr;
  logic              hold_drain;
  logic [WORD_W-1:0] hold_data;

  // A held word takes priority over a bypass; it drains on the last byte or from IDLE.
  always_comb begin
    ready_in   = !hold_full;
    accept     = flat_in && ready_in;
    hold_wr    = accept && (state_q != IDLE);
    hold_drain = hold_full && (last_done || (state_q == IDLE));
    start_new  = hold_drain || (accept && (state_q == IDLE));
    new_word   = hold_drain ? hold_data : data_in;
  end

  palabra_hold_reg #(
    .WIDTH(WORD_W)
  ) u_hold (
    .clk_i  (clk),
    .rst_ni (rst),
    .wr_i   (hold_wr),
    .drain_i(hold_drain),
    .data_i (data_in),
    .data_o (hold_data),
    .full_o (hold_full)
  );
`else
  always_comb begin
    ready_in  = (state_q == IDLE);
    accept    = flat_in && ready_in;
    start_new = accept;
    new_word  = data_in;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      tx_dato_q   <= '0;
      tx_start_q  <= 1'b0;
      flat_done_q <= 1'b0;
    end else begin
      tx_start_q  <= 1'b0;
      flat_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_new) begin
            state_q    <= START;
            shreg_q    <= new_word;
            cnt_q      <= '0;
            tx_start_q <= 1'b1;
            tx_dato_q  <= new_word[BYTE_W-1:0];
          end
        end
        START: state_q <= WAIT;
        WAIT: begin
          if (last_done) begin
            flat_done_q <= 1'b1;
            cnt_q       <= '0;
            if (start_new) begin
              state_q    <= START;
              shreg_q    <= new_word;
              tx_start_q <= 1'b1;
              tx_dato_q  <= new_word[BYTE_W-1:0];
            end else begin
              state_q <= IDLE;
            end
          end else if (tx_done) begin
            shreg_q    <= shreg_q >> BYTE_W;
            cnt_q      <= cnt_q + CNT_W'(1);
            state_q    <= START;
            tx_start_q <= 1'b1;
            tx_dato_q  <= shreg_q[2*BYTE_W-1:BYTE_W];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_dato   = tx_dato_q;
  assign tx_start  = tx_start_q;
  assign flat_done = flat_done_q;

endmodule

// File: tb/tb_split_palabras.sv
// Scoreboard bench for split_palabras: model predicts bytes and pulse timing, monitor compares.
module tb_split_palabras;
  import palabras_pkg::*;

  localparam int P = 2;
  localparam int W = P * 8;
`ifdef SPLIT_PALABRAS_HOLD_BUF_EN
  localparam int LIM = 2;
`else
  localparam int LIM = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         flat_in = 1'b0;
  logic         ready_in;
  logic [7:0]   tx_dato;
  logic         tx_start;
  logic         tx_done;
  logic         flat_done;
  logic         tx_done_r = 1'b0;
  logic         inj_done = 1'b0;

  assign tx_done = tx_done_r | inj_done;

  always #5 clk = ~clk;

  split_palabras #(
    .PALABRAS_ESCALE(P),
    .BITS_ESCALE    (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .flat_in  (flat_in),
    .ready_in (ready_in),
    .tx_dato  (tx_dato),
    .tx_start (tx_start),
    .tx_done  (tx_done),
    .flat_done(flat_done)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words in flight, expected byte stream, expected pulse timing.
  logic [7:0]  exp_q[$];
  int          pending = 0;
  int          done_cnt = 0;
  int unsigned acc_cnt = 0;
  bit          start_due = 1'b0;
  bit          exp_fd = 1'b0;
  bit          model_ready = 1'b1;
  bit          rand_lat = 1'b0;

  initial begin
    bit rdy, sd, fd;
    int pb;
    forever begin
      @(posedge clk);
      if (!rst) begin
        pending = 0;
        done_cnt = 0;
        exp_q.delete();
        start_due = 1'b0;
        exp_fd = 1'b0;
        model_ready = 1'b1;
      end else begin
        pb  = pending;
        rdy = (pending < LIM);
        sd  = 1'b0;
        fd  = 1'b0;
        if (tx_done_r) begin
          done_cnt++;
          if (done_cnt == P) begin
            done_cnt = 0;
            pending--;
            fd = 1'b1;
            if (pending > 0) sd = 1'b1;
          end else begin
            sd = 1'b1;
          end
        end
        if (flat_in && rdy) begin
          for (int k = 0; k < P; k++) exp_q.push_back(data_in[8*k +: 8]);
          if (pb == 0) sd = 1'b1;
          pending++;
          acc_cnt++;
        end
        start_due   = sd;
        exp_fd      = fd;
        model_ready = (pending < LIM);
      end
    end
  end

  // Monitor plus transmitter stand-in: checks outputs, answers each tx_start with tx_done.
  initial begin
    logic [7:0] cur;
    bit byte_active;
    int cd;
    byte_active = 1'b0;
    cd = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("reset_tx_start", tx_start, 0);
        chk("reset_flat_done", flat_done, 0);
        chk("reset_tx_dato", tx_dato, 0);
        tx_done_r = 1'b0;
        byte_active = 1'b0;
        cd = 0;
      end else begin
        chk("tx_start_timing", tx_start, start_due);
        chk("flat_done", flat_done, exp_fd);
        chk("ready_in", ready_in, model_ready);
        tx_done_r = 1'b0;
        if (tx_start) begin
          chk("exp_q_nonempty", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("tx_dato", tx_dato, cur);
            byte_active = 1'b1;
            cd = rand_lat ? int'($urandom_range(1, 6)) : 5;
          end
        end else if (byte_active) begin
          chk("tx_dato_hold", tx_dato, cur);
          cd--;
          if (cd == 0) begin
            tx_done_r = 1'b1;
            byte_active = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] w, input bit keep_high);
    int unsigned base;
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    base = acc_cnt;
    data_in = w;
    flat_in = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != base) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_within_bound", ok, 1);
    if (!keep_high) begin
      @(negedge clk);
      flat_in = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (pending == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("idle_within_bound", ok, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    send(16'hA55A, 1'b0);
    wait_idle();

    send(16'h1234, 1'b1);
    send(16'hBEEF, 1'b0);
    wait_idle();

    @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    repeat (3) @(negedge clk);
    send(16'h5678, 1'b0);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    wait_idle();

    send(16'hCAFE, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    send(16'h0102, 1'b0);
    wait_idle();

`ifdef SPLIT_PALABRAS_HOLD_BUF_EN
    send(16'h1111, 1'b1);
    send(16'h2222, 1'b0);
    wait_idle();
`endif

    rand_lat = 1'b1;
    for (int n = 0; n < 24; n++) begin
`ifdef SPLIT_PALABRAS_HOLD_BUF_EN
      wait_idle();
`endif
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(W'($urandom), 1'b0);
    end
    wait_idle();
    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/split_palabras.md
Name: split_palabras

Overview:
Transmit-side counterpart of the byte-to-word assembler. Accepts one PALABRAS_ESCALE*8-bit word through a valid/ready handshake and serialises it into 8-bit bytes for the UART transmitter, least-significant byte first. It handshakes each byte with the transmitter via a start pulse and a done pulse. Sits between the result/datapath side and the UART TX core.

Parameters:
PALABRAS_ESCALE, 2, number of 8-bit bytes per word (legal range 2..8)
BITS_ESCALE, 2, byte counter MSB index; counter width is BITS_ESCALE+1 and must hold PALABRAS_ESCALE-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
data_in  input  PALABRAS_ESCALE*8  word to send, sampled on accept
flat_in  input  1  data_in valid
ready_in  output  1  block can accept a word this cycle
tx_dato  output  8  byte presented to the UART TX
tx_start  output  1  one-cycle pulse: transmitter loads tx_dato
tx_done  input  1  one-cycle pulse from the transmitter: byte finished
flat_done  output  1  one-cycle pulse: last byte of the word finished

Behaviour:
- Reset (rst low, async): state IDLE, counter 0, shift register 0, tx_dato 8'h00, tx_start 0, flat_done 0. ready_in reads 1 once rst is high.
- Accept: data_in is captured when flat_in && ready_in at a rising edge. If flat_in is high while ready_in is low, the word is ignored and not captured. No back-pressure memory.
- ready_in is combinational: 1 only in IDLE. A variant applies when the hold buffer is enabled (see Optional Feature).
- FSM states:
  - IDLE -> START on accept. The word is loaded into the shift register and the counter cleared.
  - START: tx_start=1 for exactly this cycle, and tx_dato=shreg[7:0] (registered, valid from this cycle). Unconditional -> WAIT.
  - WAIT: tx_dato is held stable. On tx_done:
    - If counter == PALABRAS_ESCALE-1: flat_done pulses the next cycle, the counter clears, and the state goes to IDLE.
    - Otherwise: shreg shifts right by 8, the counter increments, and the state goes to START.
- Latency:
  - Accept at edge N gives tx_start high in cycle N+1.
  - tx_done sampled at edge M gives the next tx_start in cycle M+1.
  - Word throughput is PALABRAS_ESCALE*(2 + transmitter time) cycles plus 1 idle cycle.
- Byte order: byte k is data_in[8k+7:8k] for k = 0..PALABRAS_ESCALE-1. Byte k goes out k-th.
- tx_done outside WAIT (IDLE or START): ignored, with no state change.
- tx_done in the same cycle as flat_done: not possible, because flat_done is registered from the WAIT exit.
- Reset mid-word: the word is abandoned. No flat_done, and no further tx_start after reset release.
- Counter arithmetic is modulo 2^(BITS_ESCALE+1). With legal parameters it never wraps.

Optional Feature:
Macro SPLIT_PALABRAS_HOLD_BUF_EN.
- With it:
  - A one-word hold register plus a full flag is added, and ready_in = !hold_full.
  - A word accepted while the FSM is not in IDLE goes into the hold register.
  - On the WAIT->IDLE exit with hold_full set, the FSM goes directly to START with the held word, and hold_full clears in the same edge.
  - If accept and hold-drain happen at the same edge, the new word is written and hold_full stays 1.
  - In IDLE with the hold empty, an accepted word bypasses the hold register.
  - Reset clears hold_full.
- Without it: behaviour is exactly as above, with no hold register.

Decomposition:
- Package palabras_pkg holds:
  - BYTE_W = 8
  - typedef enum logic [1:0] {IDLE, START, WAIT} split_state_t
  - a function checking PALABRAS_ESCALE <= 2**(BITS_ESCALE+1)
- The receiver may also import BYTE_W from this package.
- Sub-module: palabra_hold_reg (hold register + full flag, parameterised width), instantiated only under SPLIT_PALABRAS_HOLD_BUF_EN. The FSM and shift register stay in split_palabras.

Test Plan:
- Reset low for 3 cycles, then release. Expect tx_start=0, flat_done=0, tx_dato=8'h00, ready_in=1.
- Single word, transmitter responds with tx_done 5 cycles after each tx_start.
  - Stimulus: data_in=16'hA55A, flat_in for 1 cycle.
  - Expect tx_start with tx_dato=8'h5A, then tx_start with 8'hA5, and tx_dato stable through each WAIT.
  - Expect flat_done one cycle after the second tx_done, and ready_in back to 1.
- Send 16'h1234 and hold flat_in high with 16'hBEEF during transmission.
  - Without the macro: 16'hBEEF is ignored until IDLE.
  - Sent sequence: 34, 12, then EF, BE (accepted at return to IDLE).
- Inject tx_done in IDLE and in the START cycle. Expect no state change, no extra tx_start, and no flat_done.
- Assert rst low during WAIT of byte 0 of 16'hCAFE.
  - Expect outputs reset immediately, no flat_done, and no tx_start after release until a new accept.
  - Then send 16'h0102: expect bytes 02, 01.
- With SPLIT_PALABRAS_HOLD_BUF_EN: accept 16'h1111 and, one cycle later, 16'h2222.
  - Expect ready_in=0 until the first word completes.
  - Expect bytes 11, 11, 22, 22, with START for 16'h2222 immediately after the first flat_done edge (no IDLE cycle).
